// File: rtl/ga23_sdr_arbiter.sv
// ga23_sdr_arbiter
// Round-robin arbiter that latches one-cycle tile-row fetch requests from the
// GA23 layer fetchers and serialises them onto a single SDRAM read port.
// Each completed row is returned to its requester with a one-cycle ready pulse
// and held on that requester's rsp_data slice until its next completion.
module ga23_sdr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 22,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ*DATA_W-1:0] rsp_data,
    output logic [NUM_REQ-1:0]        rsp_rdy,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic                      mem_ack,
    input  logic [DATA_W-1:0]         mem_data,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]                r_state;
    logic [NUM_REQ-1:0]        r_pending;
    logic [ADDR_W-1:0]         r_addr_lat [NUM_REQ];
    logic [IDX_W-1:0]          r_cur;
    logic [IDX_W-1:0]          r_rr;
    logic                      r_mem_req;
    logic [ADDR_W-1:0]         r_mem_addr;
    logic                      r_busy;
    logic [NUM_REQ-1:0]        r_rsp_rdy;
    logic [NUM_REQ*DATA_W-1:0] r_rsp_data;

    logic                      w_any;
    logic [IDX_W-1:0]          w_grant;
    logic [ADDR_W-1:0]         w_grant_addr;
    logic                      w_issue;
    logic                      w_done;
    logic [IDX_W-1:0]          w_rr_next;

    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign busy     = r_busy;
    assign rsp_rdy  = r_rsp_rdy;
    assign rsp_data = r_rsp_data;

    // Round-robin pick: first pending requester at or after r_rr, wrapping.
    // Offsets are scanned from the far end so the nearest one is the last
    // assignment and therefore the winner.
    always_comb begin
        int s;
        w_any        = 1'b0;
        w_grant      = '0;
        w_grant_addr = '0;
        s            = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            s = int'(r_rr) + k;
            if (s >= NUM_REQ) begin
                s = s - NUM_REQ;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (r_pending[j] && (j == s)) begin
                    w_any        = 1'b1;
                    w_grant      = IDX_W'(j);
                    w_grant_addr = r_addr_lat[j];
                end
            end
        end
    end

    assign w_issue   = (r_state == ST_IDLE) && w_any;
    assign w_done    = (r_state == ST_BUSY) && mem_ack;
    assign w_rr_next = (r_cur == IDX_W'(NUM_REQ - 1)) ? '0 : r_cur + 1'b1;

    // Transfer FSM: issue one latched request, hold mem_req/mem_addr until the ack.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_cur      <= '0;
            r_rr       <= '0;
            r_busy     <= 1'b0;
        end else if (w_issue) begin
            r_state    <= ST_BUSY;
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_grant_addr;
            r_cur      <= w_grant;
            r_busy     <= 1'b1;
        end else if (w_done) begin
            r_state    <= ST_IDLE;
            r_mem_req  <= 1'b0;
            r_busy     <= 1'b0;
            r_rr       <= w_rr_next;
        end
    end

    // Pending flags: a new request always wins over the clear caused by issuing it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pending <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i]) begin
                    r_pending[i] <= 1'b1;
                end else if (w_issue && (w_grant == IDX_W'(i))) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    // Address latches: newest request address overwrites any unissued one.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i]) begin
                r_addr_lat[i] <= req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Completion: capture SDRAM data into the current requester's slice and pulse its ready.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rsp_rdy  <= '0;
            r_rsp_data <= '0;
        end else begin
            r_rsp_rdy <= '0;
            if (w_done) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (r_cur == IDX_W'(i)) begin
                        r_rsp_rdy[i]                    <= 1'b1;
                        r_rsp_data[i*DATA_W +: DATA_W] <= mem_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ga23_sdr_arbiter.sv
// tb_ga23_sdr_arbiter
// Self-checking bench for ga23_sdr_arbiter: scenario tasks plus a randomized
// run, compared cycle by cycle against a transaction-level reference model.
module tb_ga23_sdr_arbiter;

    localparam int N  = 3;
    localparam int AW = 22;
    localparam int DW = 32;

    logic              clk;
    logic              reset_n;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   rsp_data;
    logic [N-1:0]      rsp_rdy;
    logic              mem_req;
    logic [AW-1:0]     mem_addr;
    logic              mem_ack;
    logic [DW-1:0]     mem_data;
    logic              busy;

    ga23_sdr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_addr (req_addr),
        .rsp_data (rsp_data),
        .rsp_rdy  (rsp_rdy),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // reference model state
    logic            m_pend [N];
    logic [AW-1:0]   m_addr [N];
    logic            m_busy = 1'b0;
    int              m_cur = 0;
    int              m_rr = 0;
    logic            m_mem_req = 1'b0;
    logic [AW-1:0]   m_mem_addr = '0;
    logic [N-1:0]    m_rdy = '0;
    logic [N*DW-1:0] m_rsp_data = '0;

    // memory responder and monitors
    bit              auto_ack = 0;
    bit              rand_delay = 0;
    int              ack_delay = 3;
    int              wcnt = 0;
    logic            prev_req = 1'b0;
    logic [AW-1:0]   issued [$];
    logic [N-1:0]    rdy_log [$];

    // One clock edge of the arbiter as described by its rules.
    task automatic model_update();
        logic [N-1:0] rdy;
        int g;
        rdy = '0;
        if (!reset_n) begin
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            m_busy = 1'b0; m_cur = 0; m_rr = 0;
            m_mem_req = 1'b0; m_mem_addr = '0;
            m_rdy = '0; m_rsp_data = '0;
            return;
        end
        if (!m_busy) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                int idx = (m_rr + k) % N;
                if (g < 0 && m_pend[idx]) g = idx;
            end
            if (g >= 0) begin
                m_mem_req  = 1'b1;
                m_mem_addr = m_addr[g];
                m_cur      = g;
                m_busy     = 1'b1;
                m_pend[g]  = 1'b0;
            end
        end else if (mem_ack) begin
            m_rsp_data[m_cur*DW +: DW] = mem_data;
            rdy[m_cur] = 1'b1;
            m_mem_req  = 1'b0;
            m_busy     = 1'b0;
            m_rr       = (m_cur + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                m_pend[i] = 1'b1;
                m_addr[i] = req_addr[i*AW +: AW];
            end
        end
        m_rdy = rdy;
    endtask

    // Advance one clock: responder drives mem_ack, model and DUT see the same edge.
    task automatic step();
        if (auto_ack) begin
            if (mem_req && !mem_ack) begin
                wcnt++;
                if (wcnt >= ack_delay) begin
                    mem_ack  = 1'b1;
                    mem_data = $urandom;
                    wcnt     = 0;
                    if (rand_delay) ack_delay = $urandom_range(1, 5);
                end
            end else begin
                mem_ack = 1'b0;
                if (!mem_req) wcnt = 0;
            end
        end
        @(posedge clk);
        model_update();
        #1;
        if (mem_req && !prev_req) issued.push_back(mem_addr);
        prev_req = mem_req;
        if (rsp_rdy != '0) rdy_log.push_back(rsp_rdy);
        req = '0;
    endtask

    task automatic do_reset();
        auto_ack = 0; rand_delay = 0; mem_ack = 1'b0; wcnt = 0;
        req = '0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        issued.delete();
        rdy_log.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = '1; req_addr = '1; mem_ack = 1'b1; mem_data = '1;
        step();
        mem_ack = 1'b0;
        step();
        n_chk++;
        if ({mem_req, busy, rsp_rdy} !== '0 || mem_addr !== '0 || rsp_data !== '0) begin
            n_fail++;
            $display("FAIL reset: got req=%b busy=%b rdy=%b addr=%h data=%h, want all zero",
                     mem_req, busy, rsp_rdy, mem_addr, rsp_data);
        end else n_pass++;
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_chk++;
            if ({mem_req, busy, rsp_rdy} !== '0) begin
                n_fail++;
                $display("FAIL reset_idle c=%0d: got req=%b busy=%b rdy=%b, want 0", c, mem_req, busy, rsp_rdy);
            end else n_pass++;
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            case (c)
                0: begin req[1] = 1'b1; req_addr[1*AW +: AW] = 22'h12345; end
                5: begin mem_ack = 1'b1; mem_data = 32'hDEADBEEF; end
                default: ;
            endcase
            step();
            mem_ack = 1'b0;
            n_chk++;
            if ({mem_req, mem_addr, busy, rsp_rdy, rsp_data} !== {m_mem_req, m_mem_addr, m_busy, m_rdy, m_rsp_data}) begin
                n_fail++;
                $display("FAIL single c=%0d: got req=%b addr=%h busy=%b rdy=%b data=%h, want req=%b addr=%h busy=%b rdy=%b data=%h",
                         c, mem_req, mem_addr, busy, rsp_rdy, rsp_data, m_mem_req, m_mem_addr, m_busy, m_rdy, m_rsp_data);
            end else n_pass++;
            if (c == 1) begin
                n_chk++;
                if (mem_req !== 1'b1 || mem_addr !== 22'h12345 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_issue: got req=%b addr=%h busy=%b, want 1 012345 1", mem_req, mem_addr, busy);
                end else n_pass++;
            end
            if (c == 5) begin
                n_chk++;
                if (rsp_rdy !== 3'b010 || rsp_data[1*DW +: DW] !== 32'hDEADBEEF || mem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_rsp: got rdy=%b data1=%h req=%b, want 010 deadbeef 0", rsp_rdy, rsp_data[1*DW +: DW], mem_req);
                end else n_pass++;
            end
            if (c == 7) begin
                n_chk++;
                if (rsp_rdy !== 3'b000 || rsp_data[1*DW +: DW] !== 32'hDEADBEEF || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_hold: got rdy=%b data1=%h busy=%b, want 000 deadbeef 0", rsp_rdy, rsp_data[1*DW +: DW], busy);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_simultaneous();
        int rdy_cyc [$];
        do_reset();
        auto_ack = 1; ack_delay = 3;
        for (int c = 0; c < 18; c++) begin
            if (c == 0) begin
                req = 3'b111;
                req_addr = {22'h300, 22'h200, 22'h100};
            end
            step();
            if (rsp_rdy != '0) rdy_cyc.push_back(c);
            n_chk++;
            if ({mem_req, mem_addr, busy, rsp_rdy, rsp_data} !== {m_mem_req, m_mem_addr, m_busy, m_rdy, m_rsp_data}) begin
                n_fail++;
                $display("FAIL simul c=%0d: got req=%b addr=%h busy=%b rdy=%b data=%h, want req=%b addr=%h busy=%b rdy=%b data=%h",
                         c, mem_req, mem_addr, busy, rsp_rdy, rsp_data, m_mem_req, m_mem_addr, m_busy, m_rdy, m_rsp_data);
            end else n_pass++;
        end
        n_chk++;
        if (issued.size() != 3 || issued[0] !== 22'h100 || issued[1] !== 22'h200 || issued[2] !== 22'h300) begin
            n_fail++;
            $display("FAIL simul_order: got %0d issues first=%h, want 100,200,300", issued.size(),
                     (issued.size() > 0) ? issued[0] : 22'h0);
        end else n_pass++;
        n_chk++;
        if (rdy_log.size() != 3 || rdy_log[0] !== 3'b001 || rdy_log[1] !== 3'b010 || rdy_log[2] !== 3'b100) begin
            n_fail++;
            $display("FAIL simul_rdy: got %0d pulses, want 001,010,100", rdy_log.size());
        end else n_pass++;
        n_chk++;
        if (rdy_cyc.size() != 3 || rdy_cyc[0] != 4 || rdy_cyc[1] != 8 || rdy_cyc[2] != 12) begin
            n_fail++;
            $display("FAIL simul_timing: got %0d pulses first at %0d, want cycles 4,8,12", rdy_cyc.size(),
                     (rdy_cyc.size() > 0) ? rdy_cyc[0] : -1);
        end else n_pass++;
    endtask

    task automatic test_fairness();
        int n2;
        do_reset();
        auto_ack = 1; ack_delay = 2;
        for (int c = 0; c < 30; c++) begin
            req[0] = 1'b1;
            req_addr[0*AW +: AW] = AW'($urandom_range(0, 32'h1FFFF));
            if (c == 2) begin
                req[2] = 1'b1;
                req_addr[2*AW +: AW] = 22'h2AAAA;
            end
            step();
            n_chk++;
            if ({mem_req, mem_addr, busy, rsp_rdy, rsp_data} !== {m_mem_req, m_mem_addr, m_busy, m_rdy, m_rsp_data}) begin
                n_fail++;
                $display("FAIL fair c=%0d: got req=%b addr=%h busy=%b rdy=%b data=%h, want req=%b addr=%h busy=%b rdy=%b data=%h",
                         c, mem_req, mem_addr, busy, rsp_rdy, rsp_data, m_mem_req, m_mem_addr, m_busy, m_rdy, m_rsp_data);
            end else n_pass++;
        end
        n2 = 0;
        foreach (rdy_log[i]) if (rdy_log[i] == 3'b100) n2++;
        n_chk++;
        if (issued.size() < 2 || issued[1] !== 22'h2AAAA || n2 != 1) begin
            n_fail++;
            $display("FAIL fair_r2: got second issue=%h r2 pulses=%0d, want 2aaaa and 1",
                     (issued.size() > 1) ? issued[1] : 22'h0, n2);
        end else n_pass++;
    endtask

    task automatic test_overwrite();
        int n1;
        do_reset();
        auto_ack = 1; ack_delay = 4;
        for (int c = 0; c < 16; c++) begin
            case (c)
                0: begin req[0] = 1'b1; req_addr[0*AW +: AW] = 22'h001; end
                2: begin req[1] = 1'b1; req_addr[1*AW +: AW] = 22'h0AA; end
                3: begin req[1] = 1'b1; req_addr[1*AW +: AW] = 22'h0BB; end
                default: ;
            endcase
            step();
            n_chk++;
            if ({mem_req, mem_addr, busy, rsp_rdy, rsp_data} !== {m_mem_req, m_mem_addr, m_busy, m_rdy, m_rsp_data}) begin
                n_fail++;
                $display("FAIL overwr c=%0d: got req=%b addr=%h busy=%b rdy=%b data=%h, want req=%b addr=%h busy=%b rdy=%b data=%h",
                         c, mem_req, mem_addr, busy, rsp_rdy, rsp_data, m_mem_req, m_mem_addr, m_busy, m_rdy, m_rsp_data);
            end else n_pass++;
        end
        n1 = 0;
        foreach (rdy_log[i]) if (rdy_log[i] == 3'b010) n1++;
        n_chk++;
        if (issued.size() != 2 || issued[0] !== 22'h001 || issued[1] !== 22'h0BB || n1 != 1) begin
            n_fail++;
            $display("FAIL overwr_seq: got %0d issues second=%h r1 pulses=%0d, want 2 issues 001,0bb and 1",
                     issued.size(), (issued.size() > 1) ? issued[1] : 22'h0, n1);
        end else n_pass++;
    endtask

    task automatic test_rerequest();
        int n0;
        do_reset();
        auto_ack = 1; ack_delay = 3;
        for (int c = 0; c < 14; c++) begin
            case (c)
                0: begin req[0] = 1'b1; req_addr[0*AW +: AW] = 22'h010; end
                2: begin req[0] = 1'b1; req_addr[0*AW +: AW] = 22'h020; end
                default: ;
            endcase
            step();
            n_chk++;
            if ({mem_req, mem_addr, busy, rsp_rdy, rsp_data} !== {m_mem_req, m_mem_addr, m_busy, m_rdy, m_rsp_data}) begin
                n_fail++;
                $display("FAIL rereq c=%0d: got req=%b addr=%h busy=%b rdy=%b data=%h, want req=%b addr=%h busy=%b rdy=%b data=%h",
                         c, mem_req, mem_addr, busy, rsp_rdy, rsp_data, m_mem_req, m_mem_addr, m_busy, m_rdy, m_rsp_data);
            end else n_pass++;
        end
        n0 = 0;
        foreach (rdy_log[i]) if (rdy_log[i] == 3'b001) n0++;
        n_chk++;
        if (issued.size() != 2 || issued[0] !== 22'h010 || issued[1] !== 22'h020 || n0 != 2) begin
            n_fail++;
            $display("FAIL rereq_seq: got %0d issues second=%h r0 pulses=%0d, want 2 issues 010,020 and 2",
                     issued.size(), (issued.size() > 1) ? issued[1] : 22'h0, n0);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            case (c)
                0: begin req[2] = 1'b1; req_addr[2*AW +: AW] = 22'h03F; end
                3: reset_n = 1'b0;
                4: begin reset_n = 1'b1; mem_ack = 1'b1; mem_data = $urandom | 32'h1; end
                default: ;
            endcase
            step();
            mem_ack = 1'b0;
            n_chk++;
            if ({mem_req, mem_addr, busy, rsp_rdy, rsp_data} !== {m_mem_req, m_mem_addr, m_busy, m_rdy, m_rsp_data}) begin
                n_fail++;
                $display("FAIL rstmid c=%0d: got req=%b addr=%h busy=%b rdy=%b data=%h, want req=%b addr=%h busy=%b rdy=%b data=%h",
                         c, mem_req, mem_addr, busy, rsp_rdy, rsp_data, m_mem_req, m_mem_addr, m_busy, m_rdy, m_rsp_data);
            end else n_pass++;
            if (c == 2) begin
                n_chk++;
                if (mem_req !== 1'b1 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rstmid_busy: got req=%b busy=%b, want 1 1", mem_req, busy);
                end else n_pass++;
            end
            if (c == 3) begin
                n_chk++;
                if (mem_req !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rstmid_abort: got req=%b busy=%b, want 0 0", mem_req, busy);
                end else n_pass++;
            end
            if (c >= 4) begin
                n_chk++;
                if (rsp_rdy !== '0 || rsp_data !== '0 || mem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rstmid_stray c=%0d: got rdy=%b data=%h req=%b, want 0 0 0", c, rsp_rdy, rsp_data, mem_req);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        auto_ack = 1; rand_delay = 1; ack_delay = 2;
        for (int c = 0; c < 500; c++) begin
            if (c < 460 && $urandom_range(0, 3) == 0) begin
                req = N'($urandom_range(1, 7));
                for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'($urandom);
            end
            step();
            n_chk++;
            if ({mem_req, mem_addr, busy, rsp_rdy, rsp_data} !== {m_mem_req, m_mem_addr, m_busy, m_rdy, m_rsp_data}) begin
                n_fail++;
                $display("FAIL random c=%0d: got req=%b addr=%h busy=%b rdy=%b data=%h, want req=%b addr=%h busy=%b rdy=%b data=%h",
                         c, mem_req, mem_addr, busy, rsp_rdy, rsp_data, m_mem_req, m_mem_addr, m_busy, m_rdy, m_rsp_data);
            end else n_pass++;
            n_chk++;
            if (!$onehot0(rsp_rdy)) begin
                n_fail++;
                $display("FAIL random_onehot c=%0d: got rdy=%b, want at most one bit", c, rsp_rdy);
            end else n_pass++;
        end
        n_chk++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL random_drain: got req=%b busy=%b, want 0 0", mem_req, busy);
        end else n_pass++;
    endtask

    initial begin
        reset_n = 1'b0; req = '0; req_addr = '0; mem_ack = 1'b0; mem_data = '0;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_addr[i] = '0;
        end
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_overwrite();
        test_rerequest();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/ga23_sdr_arbiter.md
Name: ga23_sdr_arbiter

Overview:
- Responder side of the layer tile-row fetch interface (sdr_req / sdr_addr / sdr_data / sdr_rdy).
- Latches one-cycle requests from up to NUM_REQ layer fetchers and serialises them round-robin onto a single SDRAM read port.
- Returns each 32-bit tile row to its requester with a one-cycle ready pulse.
- Sits between the GA23 layers and the SDRAM controller's graphics read channel.

Parameters:
- NUM_REQ, 3: number of requester ports (1..8).
- ADDR_W, 22: word address width.
- DATA_W, 32: row data width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-requester one-cycle request pulse.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; slice i is sampled with req[i].
- rsp_data  out  NUM_REQ*DATA_W  packed per-requester data, held until that requester's next completion.
- rsp_rdy  out  NUM_REQ  one-cycle pulse; slice i of rsp_data is valid from this cycle.
- mem_req  out  1  level request to SDRAM, held until acknowledged.
- mem_addr  out  ADDR_W  SDRAM word address, stable while mem_req=1.
- mem_ack  in  1  one-cycle acknowledge; mem_data is valid in the same cycle.
- mem_data  in  DATA_W  SDRAM read data.
- busy  out  1  high while a transfer is in flight.

Behaviour:
- Reset (reset_n=0 at an edge) clears the following: pending=0, state=IDLE, mem_req=0, mem_addr=0, rsp_rdy=0, rsp_data=0, busy=0, rr pointer=0.
- Reset mid-transfer abandons the transfer. An ack arriving afterwards in IDLE is ignored.
- Per-requester latch: when req[i]=1 at an edge, set pending[i] and store addr_lat[i]=req_addr slice i.
  - If pending[i] is already set and not yet issued, the new address overwrites the old one. Newest wins; no error is flagged.
  - A req[i] arriving while requester i is in flight sets pending again. It is served after the current transfer completes.
- FSM states: IDLE, BUSY.
- IDLE:
  - If any pending bit is set, pick the first set index at or after the rr pointer, wrapping modulo NUM_REQ. Call it g.
  - At that edge: mem_req<=1, mem_addr<=addr_lat[g], cur<=g, busy<=1.
  - At the same edge, clear pending[g], unless req[g] is also high in that cycle. In that case pending[g] stays set and addr_lat[g] takes the new address.
  - Go to BUSY.
- BUSY:
  - mem_req and mem_addr are held unchanged.
  - On mem_ack: rsp_data slice cur<=mem_data, rsp_rdy[cur]<=1 for exactly one cycle, mem_req<=0, busy<=0, rr<=(cur+1) mod NUM_REQ. Go to IDLE.
- Latency:
  - req sampled at edge k produces mem_req high after edge k+1 (if idle).
  - mem_ack at edge m produces rsp_rdy and data visible after edge m.
  - The next issue happens at edge m+1 at the earliest, giving a one-cycle mem_req low gap between transfers.
- Simultaneous requests: all are latched in the same cycle and served one per transfer in round-robin order. No request is lost.
- rsp_rdy: at most one bit is high in any cycle. Other rsp_data slices never change.
- mem_ack in IDLE: ignored; no state change.

Test Plan:
- Reset then single request: req[1]=1, addr 0x12345 at edge 5 -> mem_req=1 and mem_addr=0x12345 after edge 6. Then mem_ack with data 0xDEADBEEF at edge 10 -> rsp_rdy=3'b010 for one cycle and slice 1=0xDEADBEEF held afterwards.
- Simultaneous requests: req=3'b111 with addrs 0x100/0x200/0x300 in one cycle, acks 3 cycles after each issue -> mem_addr sequence 0x100, 0x200, 0x300. rsp_rdy pulses 001, 010, 100 with one idle cycle between transfers.
- Round-robin fairness: requester 0 re-requests every cycle while requester 2 requests once -> requester 2 is served immediately after the current requester-0 transfer and never starved.
- Overwrite while pending: while BUSY serving requester 0, req[1] with 0x0AA then 0x0BB -> requester 1 issues 0x0BB only, and exactly one rsp_rdy[1] pulse.
- Re-request during own flight: req[0] with 0x010 issued, then req[0] with 0x020 during BUSY -> two transfers, 0x010 then 0x020, and two rsp_rdy[0] pulses.
- Reset mid-transfer and stray ack: reset_n=0 while BUSY -> mem_req=0 and busy=0 next cycle. A following mem_ack -> no rsp_rdy, rsp_data stays 0.
